branch_cond_eval: RTL



---
 rtl/cmp_pkg.sv | 32 +++
 rtl/cond_decode.sv | 65 ++++++
 rtl/branch_cond_eval.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types and constants for the branch-condition path.
//            cond_e enumerates the eight branch conditions; FLAG_* give the
//            bit positions inside the 3-bit comparison flag code.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [2:0] {
        COND_EQ     = 3'd0,
        COND_NE     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LE     = 3'd5,
        COND_ALWAYS = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    localparam int FLAG_GT = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 2;

    // ALWAYS/NEVER resolve without looking at the comparison result.
    function automatic logic cond_needs_flags(input cond_e sel);
        return !((sel == COND_ALWAYS) || (sel == COND_NEVER));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_decode.sv
`default_nettype none
// ============================================================================
// Module   : cond_decode
// Purpose  : Combinational evaluation of one branch condition against a
//            3-bit comparison flag code.
// Ports    : flags [2:0] in  - bit0 a>b, bit1 a<b, bit2 a==b
//            sel   cond_e in - requested condition
//            taken        out - condition true
//            err          out - flag code was not one-hot (checked builds)
// Config   : CMP_FLAG_CHECK_EN - when defined, a non-one-hot flag code used
//            by a flag-dependent condition forces taken=0 and err=1.
//            Otherwise err is 0 and flags decode by priority eq > lt > gt.
// Revision : 1.0 - initial release
// ============================================================================
module cond_decode
    import cmp_pkg::*;
(
    input  logic [2:0] flags,
    input  cond_e      sel,
    output logic       taken,
    output logic       err
);

    logic w_eq;
    logic w_lt;
    logic w_gt;
    logic w_raw;

    // Priority decode keeps malformed codes deterministic: any code with eq
    // set reads as equal, and 3'b000 reads as neither greater nor less.
    always_comb begin
        w_eq  = flags[FLAG_EQ];
        w_lt  = !flags[FLAG_EQ] && flags[FLAG_LT];
        w_gt  = !flags[FLAG_EQ] && !flags[FLAG_LT] && flags[FLAG_GT];
        w_raw = 1'b0;
        case (sel)
            COND_EQ:     w_raw = w_eq;
            COND_NE:     w_raw = !w_eq;
            COND_GT:     w_raw = w_gt;
            COND_LT:     w_raw = w_lt;
            COND_GE:     w_raw = w_gt | w_eq;
            COND_LE:     w_raw = w_lt | w_eq;
            COND_ALWAYS: w_raw = 1'b1;
            COND_NEVER:  w_raw = 1'b0;
            default:     w_raw = 1'b0;
        endcase
    end

`ifdef CMP_FLAG_CHECK_EN
    logic w_onehot;

    always_comb begin
        w_onehot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
        err      = cond_needs_flags(sel) && !w_onehot;
        taken    = err ? 1'b0 : w_raw;
    end
`else
    always_comb begin
        err   = 1'b0;
        taken = w_raw;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond_eval
// Purpose  : Buffers one comparison flag code and one branch-condition
//            request (each via valid/ready), evaluates the condition and
//            returns a registered taken/not-taken result with its tag.
// Ports    : clk, rst_n (async, active-low)
//            flag_valid/flag_ready/flag_code[2:0]   - flag code input
//            cond_valid/cond_ready/cond_sel[2:0]/cond_tag[TAG_W-1:0]
//                                                     - condition request
//            res_valid/res_ready/res_taken/res_tag/res_err - result output
// Config   : CMP_FLAG_CHECK_EN - enables one-hot checking of flag codes
//            (see cond_decode); res_err is constant 0 when undefined.
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import cmp_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_valid,
    output logic             flag_ready,
    input  logic [2:0]       flag_code,
    input  logic             cond_valid,
    output logic             cond_ready,
    input  logic [2:0]       cond_sel,
    input  logic [TAG_W-1:0] cond_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    logic             r_flag_full;
    logic [2:0]       r_flag_q;
    logic             r_cond_full;
    cond_e            r_sel_q;
    logic [TAG_W-1:0] r_tag_q;
    logic             r_res_valid;
    logic             r_res_taken;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    logic w_need_flags;
    logic w_fire;
    logic w_flag_take;
    logic w_cond_take;
    logic w_taken;
    logic w_err;

    // Readiness depends only on occupancy, so a buffer drained on an edge
    // cannot be refilled on that same edge.
    assign flag_ready  = !r_flag_full;
    assign cond_ready  = !r_cond_full;
    assign w_flag_take = flag_valid && !r_flag_full;
    assign w_cond_take = cond_valid && !r_cond_full;

    assign w_need_flags = cond_needs_flags(r_sel_q);
    assign w_fire       = r_cond_full && (r_flag_full || !w_need_flags)
                          && (!r_res_valid || res_ready);

    cond_decode u_decode (
        .flags (r_flag_q),
        .sel   (r_sel_q),
        .taken (w_taken),
        .err   (w_err)
    );

    // Flag buffer. ALWAYS/NEVER do not consume it, so the stored code stays
    // available for the next flag-dependent request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_full <= 1'b0;
            r_flag_q    <= 3'b000;
        end else if (w_fire && w_need_flags) begin
            r_flag_full <= 1'b0;
        end else if (w_flag_take) begin
            r_flag_full <= 1'b1;
            r_flag_q    <= flag_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond_full <= 1'b0;
            r_sel_q     <= COND_EQ;
            r_tag_q     <= '0;
        end else if (w_fire) begin
            r_cond_full <= 1'b0;
        end else if (w_cond_take) begin
            r_cond_full <= 1'b1;
            r_sel_q     <= cond_e'(cond_sel);
            r_tag_q     <= cond_tag;
        end
    end

    // Result register: reload on fire (covers back-to-back accept+fire),
    // drop valid when accepted with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_taken <= 1'b0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
        end else if (w_fire) begin
            r_res_valid <= 1'b1;
            r_res_taken <= w_taken;
            r_res_tag   <= r_tag_q;
            r_res_err   <= w_err;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_taken = r_res_taken;
    assign res_tag   = r_res_tag;
    assign res_err   = r_res_err;

endmodule
`default_nettype wire
